// File: rtl/ex2_mem_stage_if.sv
// Signal bundle between the EX1/EX2 register, the data-memory bus and writeback.
// master = the memory stage itself, slave = its surroundings (pipeline, memory, writeback).
interface ex2_mem_stage_if #(
  parameter int ADDR_W = 16
);
  logic              ex2_valid;
  logic              ex2_is_load;
  logic              ex2_is_store;
  logic [15:0]       ex2_alu_out;
  logic [15:0]       ex2_rs2;
  logic [3:0]        ex2_rd;
  logic              stall;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic [15:0]       mem_rdata;
  logic              mem_ack;
  logic              wb_valid;
  logic              wb_we;
  logic [15:0]       wb_data;
  logic [3:0]        wb_rd;
  logic              bus_err;

  modport master (
    input  ex2_valid, ex2_is_load, ex2_is_store, ex2_alu_out, ex2_rs2, ex2_rd,
    input  mem_rdata, mem_ack,
    output stall, mem_req, mem_we, mem_addr, mem_wdata,
    output wb_valid, wb_we, wb_data, wb_rd, bus_err
  );

  modport slave (
    output ex2_valid, ex2_is_load, ex2_is_store, ex2_alu_out, ex2_rs2, ex2_rd,
    output mem_rdata, mem_ack,
    input  stall, mem_req, mem_we, mem_addr, mem_wdata,
    input  wb_valid, wb_we, wb_data, wb_rd, bus_err
  );
endinterface

// File: rtl/ex2_mem_stage.sv
// EX2/memory stage: ALU ops write back 1 cycle later, loads 1 cycle after mem_ack; stall holds upstream while BUSY.
// Optional ACK_TIMEOUT_EN aborts an unacked access after TIMEOUT_CYCLES BUSY cycles and pulses bus_err.
module ex2_mem_stage #(
  parameter int          ADDR_W         = 16,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  ex2_mem_stage_if.master bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]        r_state;
  logic              r_is_load;
  logic [3:0]        r_rd;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [15:0]       r_mem_wdata;
  logic              r_wb_valid;
  logic              r_wb_we;
  logic [15:0]       r_wb_data;
  logic [3:0]        r_wb_rd;
  logic              r_bus_err;
  logic              w_mem_op;
  logic              w_timeout;
  logic              w_stall;

  assign w_mem_op = bus.ex2_is_load | bus.ex2_is_store;

`ifdef ACK_TIMEOUT_EN
  logic [7:0] r_cnt;

  // Held at zero in IDLE so every access starts its count fresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 8'd0;
    end else if (r_state == ST_IDLE) begin
      r_cnt <= 8'd0;
    end else if (!bus.mem_ack) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign w_timeout = (r_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT_CYCLES != 0);
  assign w_timeout    = 1'b0;
`endif

  always_comb begin
    w_stall = 1'b0;
    if (r_state == ST_IDLE) begin
      w_stall = bus.ex2_valid & w_mem_op;
    end else begin
      w_stall = ~bus.mem_ack;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_is_load   <= 1'b0;
      r_rd        <= 4'd0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 16'd0;
      r_wb_valid  <= 1'b0;
      r_wb_we     <= 1'b0;
      r_wb_data   <= 16'd0;
      r_wb_rd     <= 4'd0;
      r_bus_err   <= 1'b0;
    end else begin
      r_bus_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.ex2_valid && w_mem_op) begin
            r_mem_addr  <= bus.ex2_alu_out[ADDR_W-1:0];
            r_mem_wdata <= bus.ex2_rs2;
            r_mem_we    <= bus.ex2_is_store & ~bus.ex2_is_load;
            r_mem_req   <= 1'b1;
            r_rd        <= bus.ex2_rd;
            r_is_load   <= bus.ex2_is_load;
            r_wb_valid  <= 1'b0;
            r_wb_we     <= 1'b0;
            r_state     <= ST_BUSY;
          end else if (bus.ex2_valid) begin
            r_wb_valid <= 1'b1;
            r_wb_data  <= bus.ex2_alu_out;
            r_wb_rd    <= bus.ex2_rd;
            r_wb_we    <= (bus.ex2_rd != 4'd0);
          end else begin
            r_wb_valid <= 1'b0;
            r_wb_we    <= 1'b0;
          end
        end
        default: begin
          if (bus.mem_ack) begin
            r_mem_req <= 1'b0;
            r_state   <= ST_IDLE;
            if (r_is_load) begin
              r_wb_valid <= 1'b1;
              r_wb_data  <= bus.mem_rdata;
              r_wb_rd    <= r_rd;
              r_wb_we    <= (r_rd != 4'd0);
            end else begin
              r_wb_valid <= 1'b0;
              r_wb_we    <= 1'b0;
            end
          end else if (w_timeout) begin
            // An ack arriving in the expiry cycle takes the branch above instead.
            r_mem_req  <= 1'b0;
            r_bus_err  <= 1'b1;
            r_wb_valid <= 1'b0;
            r_wb_we    <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.stall     = w_stall;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.wb_valid  = r_wb_valid;
  assign bus.wb_we     = r_wb_we;
  assign bus.wb_data   = r_wb_data;
  assign bus.wb_rd     = r_wb_rd;
  assign bus.bus_err   = r_bus_err;

endmodule

// File: tb/tb_ex2_mem_stage.sv
// Scoreboard bench for ex2_mem_stage: expected writebacks and memory requests are queued at issue time.
// A memory responder and a writeback monitor pop and compare independently of the stimulus.
module tb_ex2_mem_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ex2_mem_stage_if #(.ADDR_W(16)) bus();

  ex2_mem_stage #(.ADDR_W(16), .TIMEOUT_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] data;
    logic [3:0]  rd;
    logic        we;
  } wb_t;

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [15:0] wdata;
    int          waits;
    int          len;
    logic [15:0] rdata;
  } req_t;

  wb_t  wb_q[$];
  req_t req_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   err_cnt = 0;
  int   exp_err = 0;
  logic abort_ok = 1'b0;
  logic prev_err = 1'b0;
  int   last_start = 0;
  int   prev_start = 0;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_wb(input logic [15:0] data, input logic [3:0] rd, input logic we);
    wb_t e;
    e.data = data; e.rd = rd; e.we = we;
    wb_q.push_back(e);
  endtask

  task automatic push_req(input logic [15:0] addr, input logic we, input logic [15:0] wdata,
                          input int waits, input int len, input logic [15:0] rdata);
    req_t r;
    r.addr = addr; r.we = we; r.wdata = wdata; r.waits = waits; r.len = len; r.rdata = rdata;
    req_q.push_back(r);
  endtask

  // Writeback monitor
  wb_t mon_e;
  always @(negedge clk) begin
    if (rst_n && bus.wb_valid) begin
      if (wb_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL wb_unexpected: wb_valid=1 data=0x%0h rd=%0d, expected no writeback", bus.wb_data, bus.wb_rd);
      end else begin
        mon_e = wb_q.pop_front();
        chk("wb_data", 40'(bus.wb_data), 40'(mon_e.data));
        chk("wb_rd",   40'(bus.wb_rd),   40'(mon_e.rd));
        chk("wb_we",   40'(bus.wb_we),   40'(mon_e.we));
      end
    end
  end

  always @(negedge clk) begin
    if (bus.bus_err) begin
      err_cnt++;
      chk("bus_err_width", 40'(prev_err), 40'd0);
    end
    prev_err = bus.bus_err;
  end

  // Memory responder: checks each request and acks after the queued number of wait cycles
  req_t cur;
  logic in_req = 1'b0;
  int   cyc = 0;
  int   cyc_ctr = 0;
  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 16'd0;
    forever begin
      @(posedge clk);
      #1;
      cyc_ctr++;
      bus.mem_ack = 1'b0;
      if (in_req && !bus.mem_req) begin
        if (!abort_ok) chk("req_len", 40'(cyc), 40'(cur.len));
        in_req = 1'b0;
      end
      if (bus.mem_req && !in_req) begin
        if (req_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL req_unexpected: mem_req=1 addr=0x%0h, expected no request", bus.mem_addr);
          cur.addr = bus.mem_addr; cur.we = bus.mem_we; cur.wdata = bus.mem_wdata;
          cur.waits = 0; cur.len = 1; cur.rdata = 16'd0;
        end else begin
          cur = req_q.pop_front();
          chk("req_addr",  40'(bus.mem_addr),  40'(cur.addr));
          chk("req_we",    40'(bus.mem_we),    40'(cur.we));
          chk("req_wdata", 40'(bus.mem_wdata), 40'(cur.wdata));
        end
        prev_start = last_start;
        last_start = cyc_ctr;
        in_req = 1'b1;
        cyc = 0;
      end
      if (in_req) begin
        if (cyc > 0) chk("req_stable", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, {cur.we, cur.addr, cur.wdata});
        cyc++;
        if (cyc == cur.waits + 1) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = cur.rdata;
        end
      end
    end
  end

  // Present one instruction and hold it while stall is asserted, as the upstream register would.
  task automatic issue(input logic ld, input logic st, input logic [15:0] alu, input logic [15:0] rs2,
                       input logic [3:0] rd, input int exp_stalls);
    int   n = 0;
    logic s = 1'b0;
    logic done = 1'b0;
    logic aborted = 1'b0;
    bus.ex2_valid    = 1'b1;
    bus.ex2_is_load  = ld;
    bus.ex2_is_store = st;
    bus.ex2_alu_out  = alu;
    bus.ex2_rs2      = rs2;
    bus.ex2_rd       = rd;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.bus_err) begin
        bus.ex2_valid = 1'b0;
        aborted = 1'b1;
        break;
      end
      s = bus.stall;
      if (s) n++;
      @(posedge clk);
      #1;
      if (!s) begin
        done = 1'b1;
        break;
      end
    end
    if (aborted) begin
      @(posedge clk);
      #1;
    end else if (!done) begin
      n_vec++; n_err++;
      $display("FAIL issue_timeout: stall held for 100 cycles, expected release");
    end
    chk("stall_cycles", 40'(n), 40'(exp_stalls));
  endtask

  task automatic idle(input int n);
    bus.ex2_valid    = 1'b0;
    bus.ex2_is_load  = 1'b0;
    bus.ex2_is_store = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    bus.ex2_valid    = 1'b1;
    bus.ex2_is_load  = 1'b0;
    bus.ex2_is_store = 1'b0;
    bus.ex2_alu_out  = 16'h1111;
    bus.ex2_rs2      = 16'h2222;
    bus.ex2_rd       = 4'd2;
    rst_n            = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall",     40'(bus.stall),     40'd0);
    chk("rst_mem_req",   40'(bus.mem_req),   40'd0);
    chk("rst_mem_we",    40'(bus.mem_we),    40'd0);
    chk("rst_mem_addr",  40'(bus.mem_addr),  40'd0);
    chk("rst_mem_wdata", 40'(bus.mem_wdata), 40'd0);
    chk("rst_wb_valid",  40'(bus.wb_valid),  40'd0);
    chk("rst_wb_we",     40'(bus.wb_we),     40'd0);
    chk("rst_wb_data",   40'(bus.wb_data),   40'd0);
    chk("rst_wb_rd",     40'(bus.wb_rd),     40'd0);
    chk("rst_bus_err",   40'(bus.bus_err),   40'd0);
    bus.ex2_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ALU pass-through, rd=5 then rd=0
    push_wb(16'h1234, 4'd5, 1'b1);
    issue(1'b0, 1'b0, 16'h1234, 16'h0000, 4'd5, 0);
    push_wb(16'h5678, 4'd0, 1'b0);
    issue(1'b0, 1'b0, 16'h5678, 16'h0000, 4'd0, 0);
    idle(2);

    // Load, two wait cycles
    push_req(16'h0040, 1'b0, 16'h7777, 2, 3, 16'hBEEF);
    push_wb(16'hBEEF, 4'd3, 1'b1);
    issue(1'b1, 1'b0, 16'h0040, 16'h7777, 4'd3, 3);
    idle(2);

    // Store, zero wait cycles, no writeback
    push_req(16'h0010, 1'b1, 16'hA5A5, 0, 1, 16'h0000);
    issue(1'b0, 1'b1, 16'h0010, 16'hA5A5, 4'd9, 1);
    idle(2);

    // Load then store back to back
    push_req(16'h0040, 1'b0, 16'h0000, 0, 1, 16'hCAFE);
    push_wb(16'hCAFE, 4'd6, 1'b1);
    push_req(16'h0010, 1'b1, 16'h1357, 0, 1, 16'h0000);
    issue(1'b1, 1'b0, 16'h0040, 16'h0000, 4'd6, 1);
    issue(1'b0, 1'b1, 16'h0010, 16'h1357, 4'd2, 1);
    idle(2);
    chk("b2b_gap", 40'(last_start - prev_start), 40'd2);

    // Load and store both flagged: behaves as a load
    push_req(16'h0100, 1'b0, 16'h2222, 1, 2, 16'h0F0F);
    push_wb(16'h0F0F, 4'd1, 1'b1);
    issue(1'b1, 1'b1, 16'h0100, 16'h2222, 4'd1, 2);
    idle(2);

    // Load to r0: writeback slot valid, no register write
    push_req(16'h0200, 1'b0, 16'h0000, 0, 1, 16'h4242);
    push_wb(16'h4242, 4'd0, 1'b0);
    issue(1'b1, 1'b0, 16'h0200, 16'h0000, 4'd0, 1);
    idle(2);

`ifdef ACK_TIMEOUT_EN
    push_req(16'h0020, 1'b0, 16'h0000, 255, 4, 16'h0000);
    exp_err++;
    issue(1'b1, 1'b0, 16'h0020, 16'h0000, 4'd7, 5);
    idle(2);

    push_req(16'h0030, 1'b0, 16'h0000, 3, 4, 16'h9999);
    push_wb(16'h9999, 4'd8, 1'b1);
    issue(1'b1, 1'b0, 16'h0030, 16'h0000, 4'd8, 4);
    idle(2);
`endif

    // Reset pulse in the middle of an outstanding access
    push_req(16'h0050, 1'b0, 16'h0000, 255, 0, 16'h0000);
    abort_ok         = 1'b1;
    bus.ex2_valid    = 1'b1;
    bus.ex2_is_load  = 1'b1;
    bus.ex2_is_store = 1'b0;
    bus.ex2_alu_out  = 16'h0050;
    bus.ex2_rd       = 4'd4;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_busy_req", 40'(bus.mem_req), 40'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_req",   40'(bus.mem_req),  40'd0);
    chk("rst_async_wbvld", 40'(bus.wb_valid), 40'd0);
    bus.ex2_valid   = 1'b0;
    bus.ex2_is_load = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(3);
    abort_ok = 1'b0;

    idle(2);
    chk("wb_q_drained",  40'(wb_q.size()),  40'd0);
    chk("req_q_drained", 40'(req_q.size()), 40'd0);
    chk("bus_err_count", 40'(err_cnt),      40'(exp_err));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
